// File: rtl/kws_argmax_detector.sv
// kws_argmax_detector
//
// Captures one fully connected output vector per frame and scans it serially,
// one class per cycle, to find the highest-scoring class. The lowest index
// wins a tie. The winner must be strictly above a per-frame threshold, and the
// same class must win HOLD_COUNT frames in a row before a one-cycle detect
// pulse is raised.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      FC scores, class k at [k*ACTIV_BITS +: ACTIV_BITS]
//   data_valid   frame strobe, sampled only while idle
//   threshold    minimum score, latched together with data_in
//   busy         high while a frame is being processed
//   class_out    winning class index of the last frame
//   max_value    winning score of the last frame
//   class_valid  one-cycle pulse when class_out/max_value update
//   detect       one-cycle pulse, coincident with class_valid, keyword confirmed
//   streak       consecutive above-threshold wins, saturating at HOLD_COUNT
module kws_argmax_detector #(
  parameter int unsigned NUM_CLASSES = 64,
  parameter int unsigned ACTIV_BITS  = 16,
  parameter int unsigned CLASS_BITS  = 6,
  parameter int unsigned HOLD_COUNT  = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in,
  input  logic                              data_valid,
  input  logic [ACTIV_BITS-1:0]             threshold,
  output logic                              busy,
  output logic [CLASS_BITS-1:0]             class_out,
  output logic [ACTIV_BITS-1:0]             max_value,
  output logic                              class_valid,
  output logic                              detect,
  output logic [CLASS_BITS-1:0]             streak
);

  localparam logic [CLASS_BITS-1:0] LastIdx = CLASS_BITS'(NUM_CLASSES - 1);
  localparam logic [CLASS_BITS-1:0] HoldCnt = CLASS_BITS'(HOLD_COUNT);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ACTIV_BITS-1:0]   buf_q [NUM_CLASSES];
  logic [ACTIV_BITS-1:0]   thr_q, thr_d;
  logic [CLASS_BITS-1:0]   idx_q, idx_d;
  logic [ACTIV_BITS-1:0]   best_val_q, best_val_d;
  logic [CLASS_BITS-1:0]   best_idx_q, best_idx_d;
  logic [CLASS_BITS-1:0]   class_out_q, class_out_d;
  logic [ACTIV_BITS-1:0]   max_value_q, max_value_d;
  logic                    class_valid_q, class_valid_d;
  logic                    detect_q, detect_d;
  logic [CLASS_BITS-1:0]   streak_q, streak_d;
  logic [CLASS_BITS-1:0]   last_class_q, last_class_d;

  logic                    capture;
  logic [ACTIV_BITS-1:0]   cur_val;
  logic                    hit;
  logic                    same_class;

  assign capture    = (state_q == StIdle) && data_valid;
  assign cur_val    = buf_q[idx_q];
  assign hit        = best_val_q > thr_q;
  assign same_class = best_idx_q == last_class_q;

  // Frame buffer has no reset: its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        buf_q[k] <= data_in[k*ACTIV_BITS +: ACTIV_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      thr_q         <= '0;
      idx_q         <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      class_out_q   <= '0;
      max_value_q   <= '0;
      class_valid_q <= 1'b0;
      detect_q      <= 1'b0;
      streak_q      <= '0;
      last_class_q  <= '0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      idx_q         <= idx_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      class_out_q   <= class_out_d;
      max_value_q   <= max_value_d;
      class_valid_q <= class_valid_d;
      detect_q      <= detect_d;
      streak_q      <= streak_d;
      last_class_q  <= last_class_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    idx_d         = idx_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    class_out_d   = class_out_q;
    max_value_d   = max_value_q;
    class_valid_d = 1'b0;
    detect_d      = 1'b0;
    streak_d      = streak_q;
    last_class_d  = last_class_q;

    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          thr_d      = threshold;
          idx_d      = '0;
          best_val_d = '0;
          best_idx_d = '0;
          state_d    = StScan;
        end
      end

      StScan: begin
        // Strict compare keeps the lowest index on ties.
        if (cur_val > best_val_q) begin
          best_val_d = cur_val;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
      end

      StDone: begin
        class_out_d   = best_idx_q;
        max_value_d   = best_val_q;
        class_valid_d = 1'b1;
        state_d       = StIdle;
        if (hit) begin
          if (same_class) begin
            streak_d = (streak_q >= HoldCnt) ? HoldCnt : streak_q + 1'b1;
            // Fire only on the transition into saturation, not while held there.
            detect_d = (streak_q < HoldCnt) && (streak_q + 1'b1 == HoldCnt);
          end else begin
            streak_d     = CLASS_BITS'(1);
            last_class_d = best_idx_q;
            // A new run reaches HOLD_COUNT immediately only when HOLD_COUNT is 1.
            detect_d     = (HoldCnt == CLASS_BITS'(1));
          end
        end else begin
          streak_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy        = state_q != StIdle;
  assign class_out   = class_out_q;
  assign max_value   = max_value_q;
  assign class_valid = class_valid_q;
  assign detect      = detect_q;
  assign streak      = streak_q;

endmodule

// File: tb/tb_kws_argmax_detector.sv
// Directed scoreboard bench for kws_argmax_detector: the stimulus process pushes
// hand-computed expectations; the monitor pops one on every class_valid pulse.
module tb_kws_argmax_detector;

  localparam int NC = 64;
  localparam int AB = 16;
  localparam int W  = NC * AB;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  data_in;
  logic          data_valid;
  logic [AB-1:0] threshold;
  logic          busy;
  logic [5:0]    class_out;
  logic [AB-1:0] max_value;
  logic          class_valid;
  logic          detect;
  logic [5:0]    streak;

  kws_argmax_detector #(
    .NUM_CLASSES(64),
    .ACTIV_BITS (16),
    .CLASS_BITS (6),
    .HOLD_COUNT (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .threshold  (threshold),
    .busy       (busy),
    .class_out  (class_out),
    .max_value  (max_value),
    .class_valid(class_valid),
    .detect     (detect),
    .streak     (streak)
  );

  typedef struct {
    int cls;
    int val;
    int stk;
    int det;
    int cap;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   cv_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input int cls, input int val, input int stk, input int det);
    exp_t e;
    e.cls = cls;
    e.val = val;
    e.stk = stk;
    e.det = det;
    e.cap = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] fill(input logic [AB-1:0] base, input int k1,
                                        input logic [AB-1:0] v1, input int k2,
                                        input logic [AB-1:0] v2);
    logic [W-1:0] f;
    for (int k = 0; k < NC; k++) begin
      f[k*AB +: AB] = (k == k1) ? v1 : ((k == k2) ? v2 : base);
    end
    return f;
  endfunction

  // Monitor: every class_valid consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && detect && !class_valid) chk("detect without class_valid", 1, 0);
    if (rst_n && class_valid) begin
      cv_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected class_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("class_out", int'(class_out), e.cls);
        chk("max_value", int'(max_value), e.val);
        chk("streak", int'(streak), e.stk);
        chk("detect", int'(detect), e.det);
        chk("latency", cyc - e.cap, 65);
        chk("busy low with class_valid", int'(busy), 0);
      end
    end
  end

  // Waits for idle, then captures one frame and queues its expected result.
  task automatic capture(input logic [W-1:0] d, input logic [AB-1:0] thr, input exp_t e);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("wait for idle", 1, 0);
    data_in    = d;
    threshold  = thr;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    e.cap = cyc;
    exp_q.push_back(e);
    data_valid = 1'b0;
    // Buffer must hold the frame even though data_in moves on.
    data_in    = {W{1'b1}};
    threshold  = '0;
    chk("busy after capture", int'(busy), 1);
  endtask

  initial begin
    exp_t dummy;
    int   cv0;
    int   guard;

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    threshold  = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset class_out", int'(class_out), 0);
    chk("reset max_value", int'(max_value), 0);
    chk("reset class_valid", int'(class_valid), 0);
    chk("reset detect", int'(detect), 0);
    chk("reset streak", int'(streak), 0);
    rst_n = 1'b1;

    // Single peak.
    capture(fill(16'h0010, 17, 16'h0400, -1, 16'h0), 16'h0100, mk(17, 16'h0400, 1, 0));
    // Tie: lowest index wins.
    capture(fill(16'h0000, 5, 16'h7FFF, 40, 16'h7FFF), 16'h0100, mk(5, 16'h7FFF, 1, 0));
    // All-zero frame, threshold 0: not strictly above.
    capture(fill(16'h0000, -1, 16'h0, -1, 16'h0), 16'h0000, mk(0, 0, 0, 0));
    // Streak on class 9: 1,2,3,3, detect only on the third.
    capture(fill(16'h0020, 9, 16'h0200, -1, 16'h0), 16'h0100, mk(9, 16'h0200, 1, 0));
    capture(fill(16'h0020, 9, 16'h0200, -1, 16'h0), 16'h0100, mk(9, 16'h0200, 2, 0));
    capture(fill(16'h0020, 9, 16'h0200, -1, 16'h0), 16'h0100, mk(9, 16'h0200, 3, 1));
    capture(fill(16'h0020, 9, 16'h0200, -1, 16'h0), 16'h0100, mk(9, 16'h0200, 3, 0));
    // Class change restarts the run.
    capture(fill(16'h0020, 12, 16'h0300, -1, 16'h0), 16'h0100, mk(12, 16'h0300, 1, 0));
    // Max equal to threshold is not a hit.
    capture(fill(16'h0000, 3, 16'h0100, -1, 16'h0), 16'h0100, mk(3, 16'h0100, 0, 0));

    // data_valid during scan ignored; winner is the last class.
    capture(fill(16'h0001, 63, 16'h1234, -1, 16'h0), 16'h0010, mk(63, 16'h1234, 1, 0));
    repeat (9) @(negedge clk);
    data_in    = fill(16'h0000, 2, 16'hFFFF, -1, 16'h0);
    threshold  = 16'hFFFF;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (19) @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("busy mid-scan", int'(busy), 1);

    // Reset mid-scan aborts the frame.
    capture(fill(16'h0010, 17, 16'h0400, -1, 16'h0), 16'h0100, mk(17, 16'h0400, 1, 0));
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    dummy = exp_q.pop_back();
    chk("abort busy", int'(busy), 0);
    chk("abort class_out", int'(class_out), 0);
    chk("abort max_value", int'(max_value), 0);
    chk("abort class_valid", int'(class_valid), 0);
    chk("abort detect", int'(detect), 0);
    chk("abort streak", int'(streak), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cv0 = cv_seen;
    repeat (80) @(negedge clk);
    chk("no class_valid after abort", cv_seen - cv0, 0);
    capture(fill(16'h0010, 17, 16'h0400, -1, 16'h0), 16'h0100, mk(17, 16'h0400, 1, 0));

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard drained", exp_q.size(), 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kws_argmax_detector.md
# kws_argmax_detector

Downstream stage of the PSRAM-backed fully connected layer in the keyword-spotting pipeline. It captures one FC output vector per frame and scans it serially, one class per cycle, to find the highest-scoring class. It then applies a score threshold and requires the same class to win several consecutive frames before raising a one-cycle keyword detection pulse.

## Interface

- NUM_CLASSES, 64, number of FC outputs/classes in data_in
- ACTIV_BITS, 16, width of each class score (unsigned, post-ReLU)
- CLASS_BITS, 6, width of class index; must satisfy 2^CLASS_BITS >= NUM_CLASSES
- HOLD_COUNT, 3, consecutive identical above-threshold wins required for detect; must be >= 1

- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- data_in  input  NUM_CLASSES*ACTIV_BITS  FC scores; class k at [k*ACTIV_BITS +: ACTIV_BITS]
- data_valid  input  1  frame strobe; sampled only in IDLE
- threshold  input  ACTIV_BITS  minimum score; sampled with data_in at capture
- busy  output  1  high while state != IDLE
- class_out  output  CLASS_BITS  winning class index of last frame
- max_value  output  ACTIV_BITS  winning score of last frame
- class_valid  output  1  one-cycle pulse; class_out/max_value updated
- detect  output  1  one-cycle pulse, coincident with class_valid, keyword confirmed
- streak  output  CLASS_BITS  current consecutive-win count (saturates at HOLD_COUNT)

## Operation

- States: IDLE, SCAN, DONE.
- IDLE: on data_valid=1, latch data_in into frame buffer, latch threshold, idx<=0, best_val<=0, best_idx<=0, go to SCAN. data_valid=0: stay.
- SCAN: each cycle compare buf[idx] against best_val (unsigned). If strictly greater: best_val<=buf[idx], best_idx<=idx. idx<=idx+1. When idx==NUM_CLASSES-1, go to DONE after this compare.
- Ties: strict-greater rule, so the lowest index wins. An all-zero frame yields class 0, value 0.
- DONE (one cycle): class_out<=best_idx, max_value<=best_val, class_valid<=1, update detector, go to IDLE.
- Detector:
  - hit = best_val > threshold_latched (strict).
  - hit and best_idx==last_class: streak<=min(streak+1, HOLD_COUNT).
  - hit and best_idx!=last_class: streak<=1, last_class<=best_idx.
  - no hit: streak<=0; last_class unchanged but irrelevant.
- detect pulses only when streak transitions to HOLD_COUNT. For HOLD_COUNT=1 this means the first hit of a run. A saturated run never re-fires until streak drops below HOLD_COUNT.
- data_valid while busy=1 is ignored; no queueing, no side effects.
- Frame buffer is read only by the scan. data_in may change freely after capture.

## Timing

- Reset (async assert): state=IDLE, busy=0, class_out=0, max_value=0, class_valid=0, detect=0, streak=0, last_class=0, buffer contents don't-care.
- Capture edge E0 (IDLE, data_valid=1). busy=1 from after E0.
- SCAN compares class k at edge E(k+1), k=0..NUM_CLASSES-1.
- DONE at edge E(NUM_CLASSES+1): outputs registered. class_valid and detect are high for the cycle following that edge, and busy returns to 0 in that same cycle.
- Capture-to-class_valid latency: NUM_CLASSES+1 edges (65 at default).
- Earliest next capture: the edge ending the class_valid cycle, giving a throughput of one frame per NUM_CLASSES+2 cycles.
- class_valid and detect are single-cycle. class_out, max_value and streak hold until the next DONE.
- Reset asserted mid-SCAN or mid-DONE aborts the frame: no class_valid, streak cleared.

## Test plan

- Single peak: class 17=0x0400, all others 0x0010, threshold 0x0100 -> class_valid exactly 65 cycles after capture, class_out=17, max_value=0x0400, streak=1, detect=0.
- Tie: classes 5 and 40 both 0x7FFF, rest 0 -> class_out=5, max_value=0x7FFF.
- All-zero frame, threshold 0 -> class_out=0, max_value=0, no hit, streak=0, detect=0.
- Streak: four frames each winning class 9 above threshold -> streak 1,2,3,3; detect only on the third frame. A fifth frame winning class 12 -> streak=1, no detect. A sixth frame with max <= threshold -> streak=0.
- data_valid re-asserted on cycles 10 and 30 of a scan with a different vector -> ignored; result matches the first frame; the next capture is accepted only once busy=0.
- Reset pulsed at scan cycle 20 -> all outputs 0 immediately, no class_valid. A fresh frame afterwards completes normally with streak=1.
